// File: rtl/id_stage_pkg.sv
// Shared RV32IM decode definitions: opcodes, ALU op codes and the ID/EX payload.
package id_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17,
        ALU_PASSB  = 5'd18,
        ALU_ADDPC  = 5'd19
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        alu_op_e           alu_op;
        logic [2:0]        funct3;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              jump;
        logic              jump_r;
        logic              illegal;
    } id_ex_t;

    // Base integer op from funct3; alt is instr[30] (SUB/SRA select).
    function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
        case (f3)
            3'b000:  return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two combinational write-through read ports, one write port.
module id_stage_regfile
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_c_o,
    output logic [31:0] rdata2_c_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // x0 is hardwired; a same-cycle writeback is bypassed to the reader.
    always_comb begin
        rdata1_c_o = regs_q[raddr1_i];
        if (raddr1_i == 5'd0)                        rdata1_c_o = '0;
        else if (we_i && (waddr_i == raddr1_i))      rdata1_c_o = wdata_i;
    end

    always_comb begin
        rdata2_c_o = regs_q[raddr2_i];
        if (raddr2_i == 5'd0)                        rdata2_c_o = '0;
        else if (we_i && (waddr_i == raddr2_i))      rdata2_c_o = wdata_i;
    end

endmodule

// File: rtl/id_stage.sv
// RV32IM decode stage: decoder, immediates, register read, load-use hazard, ID/EX register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_alu_op,
    output logic [2:0]  ex_funct3,
    output logic        ex_alu_src,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_jump_r,
    output logic        ex_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_f;
    logic        op_f7_ok;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        hazard;
    id_ex_t      dec;
    id_ex_t      ex_d;
    id_ex_t      ex_q;

    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rd_f     = if_instr[11:7];
    assign op_f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) ||
                      (funct7 == 7'b0000001);

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'h000};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

    // Source-register usage; unused sources read as x0 so they never alias a hazard.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OPIMM: uses_rs1 = 1'b1;
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                uses_rs1 = op_f7_ok;
                uses_rs2 = op_f7_ok;
            end
            default: ;
        endcase
    end

    assign rs1_addr = uses_rs1 ? if_instr[19:15] : 5'd0;
    assign rs2_addr = uses_rs2 ? if_instr[24:20] : 5'd0;

    id_stage_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wb_we),
        .waddr_i    (wb_rd),
        .wdata_i    (wb_data),
        .raddr1_i   (rs1_addr),
        .raddr2_i   (rs2_addr),
        .rdata1_c_o (rs1_rdata),
        .rdata2_c_o (rs2_rdata)
    );

    always_comb begin
        dec         = '0;
        dec.alu_op  = ALU_ADD;
        dec.valid   = 1'b1;
        dec.pc      = if_pc;
        dec.funct3  = funct3;
        dec.rs1     = rs1_addr;
        dec.rs2     = rs2_addr;
        dec.rs1_val = rs1_rdata;
        dec.rs2_val = rs2_rdata;
        case (opcode)
            OPC_LUI: begin
                dec.alu_op = ALU_PASSB; dec.alu_src = 1'b1;
                dec.reg_write = 1'b1; dec.rd = rd_f; dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                dec.alu_op = ALU_ADDPC; dec.alu_src = 1'b1;
                dec.reg_write = 1'b1; dec.rd = rd_f; dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.alu_op = ALU_ADDPC; dec.alu_src = 1'b1; dec.jump = 1'b1;
                dec.reg_write = 1'b1; dec.rd = rd_f; dec.imm = imm_j;
            end
            OPC_JALR: begin
                dec.alu_op = ALU_ADDPC; dec.alu_src = 1'b1; dec.jump_r = 1'b1;
                dec.reg_write = 1'b1; dec.rd = rd_f; dec.imm = imm_i;
            end
            OPC_BRANCH: begin
                dec.alu_op = ALU_SUB; dec.branch = 1'b1; dec.imm = imm_b;
            end
            OPC_LOAD: begin
                dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
                dec.reg_write = 1'b1; dec.rd = rd_f; dec.imm = imm_i;
            end
            OPC_STORE: begin
                dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.imm = imm_s;
            end
            OPC_OPIMM: begin
                dec.alu_op = base_alu(funct3, if_instr[30], 1'b0);
                dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.rd = rd_f; dec.imm = imm_i;
            end
            OPC_OP: begin
                if (!op_f7_ok) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.rd        = rd_f;
                    if (funct7[0]) dec.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(funct3));
                    else           dec.alu_op = base_alu(funct3, if_instr[30], 1'b1);
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) dec.funct3 = '0;
    end

    // Load-use: the load in ID/EX produces a register this instruction reads.
    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((rs1_addr == ex_q.rd) || (rs2_addr == ex_q.rd));
    assign stall  = hazard && !flush;

    always_comb begin
        ex_d = dec;
        if (flush || hazard) ex_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_val    = ex_q.rs1_val;
    assign ex_rs2_val    = ex_q.rs2_val;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct3     = ex_q.funct3;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_jump_r     = ex_q.jump_r;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random stream against a decode model.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] if_instr, if_pc;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_op;
    logic [2:0]  ex_funct3;
    logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        ex_branch, ex_jump, ex_jump_r, ex_illegal;

    id_stage dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_jump_r(ex_jump_r), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1_val, rs2_val, imm;
        logic [4:0]  rs1, rs2, rd, alu_op;
        logic [2:0]  funct3;
        logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg;
        logic        branch, jump, jump_r, illegal;
    } exp_t;

    int          n_checks;
    int          n_errors;
    logic [31:0] m_regs [32];
    exp_t        m_ex, m_next, nxt;
    logic        m_haz, m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural register read as decode sees it, including same-cycle writeback.
    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_we && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic [4:0] m_alu(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            3'd0: return sub ? 5'd1 : 5'd0;
            3'd1: return 5'd2;
            3'd2: return 5'd3;
            3'd3: return 5'd4;
            3'd4: return 5'd5;
            3'd5: return sra ? 5'd7 : 5'd6;
            3'd6: return 5'd8;
            default: return 5'd9;
        endcase
    endfunction

    function automatic exp_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t       e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic       r1, r2;
        int         imm_i, imm_s, imm_b, imm_j;
        e  = '0;
        e.valid = 1'b1;
        e.pc = pc;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        r1 = 1'b0; r2 = 1'b0;
        imm_i = $signed(ins[31:20]);
        imm_s = $signed({ins[31:25], ins[11:7]});
        imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
        imm_j = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2;
        case (op)
            7'h37: begin e.imm = {ins[31:12], 12'h0}; e.alu_op = 5'd18; e.alu_src = 1; e.reg_write = 1; end
            7'h17: begin e.imm = {ins[31:12], 12'h0}; e.alu_op = 5'd19; e.alu_src = 1; e.reg_write = 1; end
            7'h6F: begin e.imm = imm_j; e.alu_op = 5'd19; e.alu_src = 1; e.reg_write = 1; e.jump = 1; end
            7'h67: begin e.imm = imm_i; e.alu_op = 5'd19; e.alu_src = 1; e.reg_write = 1; e.jump_r = 1; r1 = 1; end
            7'h63: begin e.imm = imm_b; e.alu_op = 5'd1; e.branch = 1; r1 = 1; r2 = 1; end
            7'h03: begin e.imm = imm_i; e.alu_src = 1; e.reg_write = 1; e.mem_read = 1; e.mem_to_reg = 1; r1 = 1; end
            7'h23: begin e.imm = imm_s; e.alu_src = 1; e.mem_write = 1; r1 = 1; r2 = 1; end
            7'h13: begin e.imm = imm_i; e.alu_op = m_alu(f3, 1'b0, ins[30]); e.alu_src = 1; e.reg_write = 1; r1 = 1; end
            7'h33: begin
                if (f7 == 7'h01)      begin e.alu_op = 5'd10 + 5'(f3); e.reg_write = 1; r1 = 1; r2 = 1; end
                else if (f7 == 7'h20) begin e.alu_op = m_alu(f3, 1'b1, 1'b1); e.reg_write = 1; r1 = 1; r2 = 1; end
                else if (f7 == 7'h00) begin e.alu_op = m_alu(f3, 1'b0, 1'b0); e.reg_write = 1; r1 = 1; r2 = 1; end
                else e.illegal = 1;
            end
            default: e.illegal = 1;
        endcase
        if (!e.illegal) e.funct3 = f3;
        if (e.reg_write) e.rd = ins[11:7];
        e.rs1 = r1 ? ins[19:15] : 5'd0;
        e.rs2 = r2 ? ins[24:20] : 5'd0;
        e.rs1_val = m_read(e.rs1);
        e.rs2_val = m_read(e.rs2);
        return e;
    endfunction

    // Model state advance: regfile write and ID/EX load.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ex = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else begin
            m_ex = m_next;
            if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
    end

    // Compare DUT to the model mid-cycle, then predict the next ID/EX contents.
    always @(negedge clk) begin
        chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
        chk("ex_pc", ex_pc, m_ex.pc);
        chk("ex_rs1_val", ex_rs1_val, m_ex.rs1_val);
        chk("ex_rs2_val", ex_rs2_val, m_ex.rs2_val);
        chk("ex_imm", ex_imm, m_ex.imm);
        chk("ex_rs1", 32'(ex_rs1), 32'(m_ex.rs1));
        chk("ex_rs2", 32'(ex_rs2), 32'(m_ex.rs2));
        chk("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
        chk("ex_alu_op", 32'(ex_alu_op), 32'(m_ex.alu_op));
        chk("ex_funct3", 32'(ex_funct3), 32'(m_ex.funct3));
        chk("ex_ctrl", 32'({ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                            ex_branch, ex_jump, ex_jump_r, ex_illegal}),
            32'({m_ex.alu_src, m_ex.reg_write, m_ex.mem_read, m_ex.mem_write, m_ex.mem_to_reg,
                 m_ex.branch, m_ex.jump, m_ex.jump_r, m_ex.illegal}));
        nxt     = m_decode(if_instr, if_pc);
        m_haz   = m_ex.valid && m_ex.mem_read && (m_ex.rd != 5'd0) &&
                  ((nxt.rs1 == m_ex.rd) || (nxt.rs2 == m_ex.rd));
        m_stall = m_haz && !flush;
        chk("stall", 32'(stall), 32'(m_stall));
        m_next  = (flush || m_haz) ? '0 : nxt;
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        r   = $urandom;
        case ($urandom_range(0, 11))
            0:  return {r[31:12], rd, 7'h37};
            1:  return {r[31:12], rd, 7'h17};
            2:  return {r[31:12], rd, 7'h6F};
            3:  return {r[31:20], rs1, 3'b000, rd, 7'h67};
            4:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
            5, 6: return {r[31:20], rs1, f3, rd, 7'h03};
            7:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
            8:  return {r[31:20], rs1, f3, rd, 7'h13};
            9: begin
                case ($urandom_range(0, 2))
                    0:       f7 = 7'h00;
                    1:       f7 = 7'h20;
                    default: f7 = 7'h01;
                endcase
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            10: return {r[31:25], rs2, rs1, f3, rd, 7'h33};
            default: return r;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        if_instr = ins;
        if_pc    = pc;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        drive(32'h0000_0013, 32'h0);
        #1;
        chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_alu_op", 32'(ex_alu_op), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        step(); step();
        rst = 1'b0;

        // addi x1,x0,4
        drive(32'h0040_0093, 32'h100); step();
        chk("addi_valid", 32'(ex_valid), 32'h1);
        chk("addi_rd", 32'(ex_rd), 32'h1);
        chk("addi_imm", ex_imm, 32'h4);
        chk("addi_src_wr", 32'({ex_alu_src, ex_reg_write}), 32'h3);
        chk("addi_alu", 32'(ex_alu_op), 32'h0);

        // beq x1,x2,-8
        drive(32'hFE20_8CE3, 32'h104); step();
        chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
        chk("beq_br_wr", 32'({ex_branch, ex_reg_write}), 32'h2);
        chk("beq_f3", 32'(ex_funct3), 32'h0);

        // lw x5,0(x1) then add x6,x5,x5
        drive(32'h0000_A283, 32'h108); step();
        drive(32'h0052_8333, 32'h10C); #1;
        chk("lu_stall", 32'(stall), 32'h1);
        step();
        chk("lu_bubble", 32'(ex_valid), 32'h0);
        chk("lu_stall_drop", 32'(stall), 32'h0);
        step();
        chk("lu_issue", 32'({ex_valid, ex_rs1, ex_rs2, ex_rd}), 32'({1'b1, 5'd5, 5'd5, 5'd6}));

        // add x4,x3,x0 with writeback to x3 in the same cycle
        drive(32'h0001_8233, 32'h110);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        step();
        wb_we = 1'b0;
        chk("wt_rs1", ex_rs1_val, 32'hDEAD_BEEF);
        chk("wt_rs2", ex_rs2_val, 32'h0);
        drive(32'h0000_03B3, 32'h114);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
        step();
        wb_we = 1'b0;
        chk("x0_rd", ex_rs1_val, 32'h0);
        drive(32'h0001_8233, 32'h118); step();
        chk("x3_kept", ex_rs1_val, 32'hDEAD_BEEF);

        // flush concurrent with load-use hazard
        drive(32'h0000_A283, 32'h11C); step();
        drive(32'h0052_8333, 32'h120); flush = 1'b1; #1;
        chk("fl_stall", 32'(stall), 32'h0);
        step();
        flush = 1'b0;
        chk("fl_bubble", 32'(ex_valid), 32'h0);

        drive(32'hFFFF_FFFF, 32'h124); step();
        chk("ill_flags", 32'({ex_valid, ex_illegal, ex_reg_write, ex_mem_write, ex_mem_read}),
            32'h18);

        // async reset while stalled
        drive(32'h0000_0013, 32'h128);
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
        step();
        wb_we = 1'b0;
        drive(32'h0000_A283, 32'h12C); step();
        drive(32'h0052_8333, 32'h130); #1;
        chk("ar_stall_pre", 32'(stall), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(ex_valid), 32'h0);
        chk("ar_stall", 32'(stall), 32'h0);
        chk("ar_fields", ex_pc | ex_imm | 32'(ex_rd) | 32'({ex_mem_read, ex_reg_write}), 32'h0);
        step();
        rst = 1'b0;
        drive(32'h0000_8113, 32'h200); step();
        chk("ar_x1", ex_rs1_val, 32'h0);

        // randomized stream; fetch holds its instruction while stalled
        repeat (1500) begin
            if (!m_stall) drive(rand_instr(), $urandom & 32'hFFFF_FFFC);
            flush   = ($urandom_range(0, 9) == 0);
            wb_we   = 1'($urandom);
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            step();
        end
        flush = 1'b0; wb_we = 1'b0;
        step(); step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the RV32IM five-stage pipeline, directly downstream of instruction fetch. Takes the registered instruction/PC pair from fetch, decodes it, reads the 32×32 register file with write-through from writeback, detects load-use hazards (driving fetch's `stall`), and loads the ID/EX pipeline register consumed by execute. Redirects from execute flush the stage.

## Interface
No parameters.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `if_instr`  in  32  instruction from fetch; reset/NOP = 0x00000013
- `if_pc`  in  32  PC of `if_instr`
- `flush`  in  1  redirect (branch_taken | jump | jump_r) from EX
- `wb_we`, `wb_rd`, `wb_data`  in  1/5/32  register-file write port
- `stall`  out  1  load-use hazard to fetch (combinational)
- `ex_valid`  out  1  ID/EX holds a real instruction
- `ex_pc`, `ex_rs1_val`, `ex_rs2_val`, `ex_imm`  out  32 each
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each
- `ex_alu_op`  out  5  ALU/MUL/DIV op code
- `ex_funct3`  out  3  for branch compare and load/store size
- `ex_alu_src`  out  1  1 = operand B is imm
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch`, `ex_jump`, `ex_jump_r`, `ex_illegal`  out  1 each

## Operation
- Decode from `if_instr` by opcode:
  - LUI 0110111
  - AUIPC 0010111
  - JAL 1101111
  - JALR 1100111
  - BRANCH 1100011
  - LOAD 0000011
  - STORE 0100011
  - OP-IMM 0010011
  - OP 0110011 (funct7 0000001 selects M ops)
- Any other opcode, or an OP funct7 not in {0000000, 0100000, 0000001}: `ex_illegal=1`, all write/mem/branch/jump controls 0.
- Immediates are sign-extended to 32 bits, formats I, S, B, U, J. B and J are byte offsets with bit 0 = 0.
- `uses_rs1`: all formats except U/J. `uses_rs2`: OP, BRANCH, STORE.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write-through: if `wb_we & wb_rd==rsN & rsN!=0`, the read returns `wb_data`.
- Hazard: `ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd))`.
- `stall = hazard & ~flush`.
- ID/EX update each cycle:
  - `flush` → bubble.
  - else `hazard` → bubble; fetch holds `if_instr`, so the instruction is re-decoded next cycle.
  - else load the decoded instruction with `ex_valid=1`.
- Bubble: `ex_valid=0`, all control bits 0, `ex_illegal=0`, data fields don't-care (hold 0).
- Flush takes priority over hazard when both are active.

## Timing
- Reset (async): all ID/EX outputs 0, `ex_alu_op`=ADD (0), register file cleared to 0. `stall` is 0 while ID/EX is empty.
- Latency: an instruction present on `if_instr` at edge N appears on the `ex_*` outputs after edge N.
- Load-use costs exactly one bubble. The dependent instruction issues on the next edge with `stall=0`; the loaded value then arrives via EX/MEM forwarding, outside this block.
- A writeback and a read of the same register in the same cycle return the new value (no extra cycle).
- Reset asserted mid-stall clears ID/EX immediately, so `stall` drops combinationally.

## Structure
- Shared header `rv32_defs.vh`:
  - opcode constants
  - `ALU_*` codes: ADD 0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, PASSB (LUI), ADDPC (AUIPC/JAL link)
  - NOP encoding
- One sub-module, `regfile`: 2 read ports (combinational, write-through), 1 write port, async reset.
- Decoder, immediate generator, hazard logic and the ID/EX register live in `id_stage`.

## Test plan
- `if_instr`=0x00400093 (addi x1,x0,4) → next cycle: `ex_valid=1`, `ex_rd=1`, `ex_imm=4`, `ex_alu_src=1`, `ex_reg_write=1`, `ex_alu_op=ADD`.
- 0xFE208CE3 (beq x1,x2,-8) → `ex_imm=0xFFFFFFF8`, `ex_branch=1`, `ex_reg_write=0`, `ex_funct3=0`.
- Load-use: 0x0000A283 (lw x5,0(x1)) then 0x00528333 (add x6,x5,x5) held → `stall=1` for one cycle, one bubble (`ex_valid=0`), then the add issues with `ex_rs1=ex_rs2=5`.
- Write-through and x0: `wb_we=1`, `wb_rd=3`, `wb_data=0xDEADBEEF` while decoding add x4,x3,x0 → `ex_rs1_val=0xDEADBEEF`, `ex_rs2_val=0`. A write to x0 with 0x55 is later read back as 0.
- Flush with a concurrent hazard → bubble, `stall=0`. Illegal opcode 0xFFFFFFFF → `ex_illegal=1`, no writes.
- Async reset mid-stream → all `ex_*` outputs 0 without waiting for a clock edge; x1 reads 0 afterwards.
